bin_to_bcd_display: RTL and testbench

BIN_TO_BCD_DISPLAY -- requirements
Module: bin_to_bcd_display

---
 rtl/display_pkg.sv | 19 +
 rtl/bcd_add3_digit.sv | 17 +
 rtl/bin_to_bcd_display.sv | 135 +++++++++++++
 tb/tb_bin_to_bcd_display.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared types and constants for the binary-to-BCD display front end.
package display_pkg;

    // Conversion sequencer states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FINISH = 2'd2
    } state_t;

    // Display geometry and codes
    localparam int unsigned NUM_DIGITS   = 8;
    localparam int unsigned NIBBLE_W     = 4;
    localparam int unsigned BCD_W        = NUM_DIGITS * NIBBLE_W;
    localparam int unsigned DOT_POS_W    = 3;
    localparam logic [3:0]  BLANK_NIBBLE = 4'hF;
    localparam int unsigned MAX_DISPLAY  = 99_999_999;

endpackage : display_pkg

// File: rtl/bcd_add3_digit.sv
// Double-dabble correction for one BCD nibble: add 3 when the nibble is 5 or more.
module bcd_add3_digit
    import display_pkg::*;
(
    input  logic [NIBBLE_W-1:0] nibble,
    output logic [NIBBLE_W-1:0] nibble_adj_c
);

    // Pre-shift correction so the following left shift carries into the next decade
    always_comb begin
        nibble_adj_c = nibble;
        if (nibble >= 4'd5) begin
            nibble_adj_c = nibble + 4'd3;
        end
    end

endmodule : bcd_add3_digit

// File: rtl/bin_to_bcd_display.sv
// Serial binary-to-BCD converter producing eight display digits with
// leading-zero blanking, decimal point control and overflow indication.
module bin_to_bcd_display
    import display_pkg::*;
#(
    parameter int unsigned WIDTH = 27
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     value,
    input  logic                 blank_lz,
    input  logic                 dot_en,
    input  logic [DOT_POS_W-1:0] dot_pos,
    output logic                 busy,
    output logic                 done,
    output logic [BCD_W-1:0]     digit,
    output logic [NUM_DIGITS-1:0] en_dot,
    output logic                 ovf
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    state_t                state;
    logic [BCD_W-1:0]      acc_q;
    logic [WIDTH-1:0]      bin_q;
    logic [WIDTH-1:0]      value_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  blank_q;
    logic                  dot_en_q;
    logic [DOT_POS_W-1:0]  dot_pos_q;

    logic [BCD_W-1:0]      acc_adj_c;
    logic [BCD_W-1:0]      disp_c;
    logic [NUM_DIGITS-1:0] dot_c;
    logic                  ovf_c;

    // One add-3 corrector per BCD decade of the accumulator
    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_add3
        bcd_add3_digit u_add3 (
            .nibble       (acc_q[NIBBLE_W*g +: NIBBLE_W]),
            .nibble_adj_c (acc_adj_c[NIBBLE_W*g +: NIBBLE_W])
        );
    end

    // Leading-zero blanking on the finished accumulator; digits at or right of the dot stay lit
    always_comb begin
        logic seen_nz;
        logic keep;
        seen_nz = 1'b0;
        keep    = 1'b0;
        disp_c  = acc_q;
        for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
            if (acc_q[NIBBLE_W*i +: NIBBLE_W] != 4'h0) begin
                seen_nz = 1'b1;
            end
            keep = seen_nz || (i == 0) || (dot_en_q && (DOT_POS_W'(i) <= dot_pos_q));
            if (blank_q && !keep) begin
                disp_c[NIBBLE_W*i +: NIBBLE_W] = BLANK_NIBBLE;
            end
        end
    end

    // Decimal point one-hot and overflow compare on the captured request
    always_comb begin
        dot_c = '0;
        if (dot_en_q) begin
            dot_c = NUM_DIGITS'(1) << dot_pos_q;
        end
        ovf_c = 32'(value_q) > MAX_DISPLAY;
    end

    // Sequencer: capture, WIDTH shift cycles, then publish the result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            ovf       <= 1'b0;
            digit     <= {NUM_DIGITS{BLANK_NIBBLE}};
            en_dot    <= '0;
            acc_q     <= '0;
            bin_q     <= '0;
            value_q   <= '0;
            cnt_q     <= '0;
            blank_q   <= 1'b0;
            dot_en_q  <= 1'b0;
            dot_pos_q <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        value_q   <= value;
                        bin_q     <= value;
                        blank_q   <= blank_lz;
                        dot_en_q  <= dot_en;
                        dot_pos_q <= dot_pos;
                        acc_q     <= '0;
                        cnt_q     <= CNT_W'(WIDTH - 1);
                        busy      <= 1'b1;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    {acc_q, bin_q} <= {acc_adj_c, bin_q} << 1;
                    if (cnt_q == '0) begin
                        state <= FINISH;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                FINISH: begin
                    if (ovf_c) begin
                        digit  <= {NUM_DIGITS{BLANK_NIBBLE}};
                        en_dot <= '0;
                        ovf    <= 1'b1;
                    end else begin
                        digit  <= disp_c;
                        en_dot <= dot_c;
                        ovf    <= 1'b0;
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule : bin_to_bcd_display

// File: tb/tb_bin_to_bcd_display.sv
// Directed self-checking bench for bin_to_bcd_display (WIDTH = 27).
module tb_bin_to_bcd_display;

    localparam int unsigned WIDTH = 27;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [WIDTH-1:0] value;
    logic        blank_lz;
    logic        dot_en;
    logic [2:0]  dot_pos;
    logic        busy;
    logic        done;
    logic [31:0] digit;
    logic [7:0]  en_dot;
    logic        ovf;

    int n_checks;
    int n_fail;

    bin_to_bcd_display #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .value    (value),
        .blank_lz (blank_lz),
        .dot_en   (dot_en),
        .dot_pos  (dot_pos),
        .busy     (busy),
        .done     (done),
        .digit    (digit),
        .en_dot   (en_dot),
        .ovf      (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive a request and let the next rising edge accept it (edge 0)
    task automatic launch(input int unsigned v, input logic blz, input logic den, input logic [2:0] dp);
        value    = WIDTH'(v);
        blank_lz = blz;
        dot_en   = den;
        dot_pos  = dp;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Count rising edges until done is seen; -1 when the budget expires
    task automatic wait_done(input int budget, output int edges);
        edges = -1;
        for (int e = 1; e <= budget; e++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                edges = e;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        value = '0;
        blank_lz = 1'b0;
        dot_en = 1'b0;
        dot_pos = 3'd0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: busy=%b done=%b ovf=%b expected 0 0 0", busy, done, ovf);
        end
        n_checks++;
        if (digit !== 32'hFFFF_FFFF || en_dot !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_display: digit=%h en_dot=%h expected ffffffff 00", digit, en_dot);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Started on the very first edge after reset release
    task automatic test_basic();
        int e;
        launch(12_345_678, 1'b0, 1'b0, 3'd0);
        repeat (10) @(posedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b1 || digit !== 32'hFFFF_FFFF || done !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_hold: busy=%b digit=%h done=%b expected 1 ffffffff 0", busy, digit, done);
        end
        wait_done(40, e);
        if (e > 0) e = e + 10;
        n_checks++;
        if (e != 28) begin
            n_fail++;
            $display("FAIL basic_latency: done after %0d edges expected 28", e);
        end
        n_checks++;
        if (digit !== 32'h1234_5678 || en_dot !== 8'h00 || ovf !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_result: digit=%h en_dot=%h ovf=%b busy=%b expected 12345678 00 0 0",
                     digit, en_dot, ovf, busy);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_done_pulse: done=%b expected 0 one cycle later", done);
        end
    endtask

    task automatic test_blanking();
        int e;
        launch(42, 1'b1, 1'b0, 3'd0);
        wait_done(40, e);
        n_checks++;
        if (e != 28 || digit !== 32'hFFFF_FF42) begin
            n_fail++;
            $display("FAIL blank_42: edges=%0d digit=%h expected 28 ffffff42", e, digit);
        end
        launch(0, 1'b1, 1'b0, 3'd0);
        wait_done(40, e);
        n_checks++;
        if (e != 28 || digit !== 32'hFFFF_FFF0) begin
            n_fail++;
            $display("FAIL blank_zero: edges=%0d digit=%h expected 28 fffffff0", e, digit);
        end
        launch(99_999_999, 1'b1, 1'b0, 3'd0);
        wait_done(40, e);
        n_checks++;
        if (digit !== 32'h9999_9999 || ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL blank_max: digit=%h ovf=%b expected 99999999 0", digit, ovf);
        end
    endtask

    task automatic test_dot();
        int e;
        launch(5, 1'b1, 1'b1, 3'd2);
        wait_done(40, e);
        n_checks++;
        if (digit !== 32'hFFFF_F005 || en_dot !== 8'h04) begin
            n_fail++;
            $display("FAIL dot_005: digit=%h en_dot=%h expected fffff005 04", digit, en_dot);
        end
        launch(1234, 1'b0, 1'b1, 3'd7);
        wait_done(40, e);
        n_checks++;
        if (digit !== 32'h0000_1234 || en_dot !== 8'h80) begin
            n_fail++;
            $display("FAIL dot_pos7: digit=%h en_dot=%h expected 00001234 80", digit, en_dot);
        end
    endtask

    task automatic test_overflow();
        int e;
        launch(100_000_000, 1'b0, 1'b1, 3'd3);
        wait_done(40, e);
        n_checks++;
        if (digit !== 32'hFFFF_FFFF || en_dot !== 8'h00 || ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_set: digit=%h en_dot=%h ovf=%b expected ffffffff 00 1", digit, en_dot, ovf);
        end
        launch(7, 1'b0, 1'b0, 3'd0);
        wait_done(40, e);
        n_checks++;
        if (digit !== 32'h0000_0007 || ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_clear: digit=%h ovf=%b expected 00000007 0", digit, ovf);
        end
    endtask

    // Second pulse while busy is dropped; the changed inputs must not leak in
    task automatic test_ignore_start();
        int n_done;
        logic [31:0] got;
        n_done = 0;
        got = '0;
        launch(321, 1'b0, 1'b0, 3'd0);
        repeat (4) @(posedge clk);
        #1;
        value = WIDTH'(999);
        blank_lz = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 0; i < 70; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                n_done++;
                got = digit;
            end
        end
        n_checks++;
        if (n_done != 1) begin
            n_fail++;
            $display("FAIL ignore_count: %0d done pulses expected 1", n_done);
        end
        n_checks++;
        if (got !== 32'h0000_0321) begin
            n_fail++;
            $display("FAIL ignore_value: digit=%h expected 00000321", got);
        end
    endtask

    // start held through done launches the next conversion on the following edge
    task automatic test_back_to_back();
        int e;
        value = WIDTH'(111);
        blank_lz = 1'b0;
        dot_en = 1'b0;
        dot_pos = 3'd0;
        start = 1'b1;
        @(posedge clk);
        #1;
        wait_done(40, e);
        n_checks++;
        if (e != 28 || digit !== 32'h0000_0111) begin
            n_fail++;
            $display("FAIL b2b_first: edges=%0d digit=%h expected 28 00000111", e, digit);
        end
        value = WIDTH'(222);
        @(posedge clk);
        #1;
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_restart: busy=%b expected 1", busy);
        end
        wait_done(40, e);
        n_checks++;
        if (e != 28 || digit !== 32'h0000_0222) begin
            n_fail++;
            $display("FAIL b2b_second: edges=%0d digit=%h expected 28 00000222", e, digit);
        end
    endtask

    task automatic test_reset_mid();
        int e;
        int n_done;
        n_done = 0;
        launch(55_555_555, 1'b0, 1'b1, 3'd1);
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || ovf !== 1'b0 || digit !== 32'hFFFF_FFFF || en_dot !== 8'h00) begin
            n_fail++;
            $display("FAIL midreset_values: busy=%b done=%b ovf=%b digit=%h en_dot=%h expected 0 0 0 ffffffff 00",
                     busy, done, ovf, digit, en_dot);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) n_done++;
        end
        n_checks++;
        if (n_done != 0) begin
            n_fail++;
            $display("FAIL midreset_nodone: %0d done pulses expected 0", n_done);
        end
        launch(87_654_321, 1'b0, 1'b0, 3'd0);
        wait_done(40, e);
        n_checks++;
        if (e != 28 || digit !== 32'h8765_4321 || ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_recover: edges=%0d digit=%h ovf=%b expected 28 87654321 0", e, digit, ovf);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        test_reset();
        test_basic();
        test_blanking();
        test_dot();
        test_overflow();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule : tb_bin_to_bcd_display
